// File: rtl/store_buffer_drain.sv
// Post-commit store buffer: holds retired stores in a small circular queue,
// drains them in order to the dcache write port with a hold-until-resp
// handshake, and answers combinational store-to-load forwarding look-ups.
module store_buffer_drain #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [ADDR_W-1:0] commit_addr,
  input  logic [3:0]        commit_mask,
  input  logic [31:0]       commit_data,
  output logic              commit_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_resp,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [3:0]        ld_rmask,
  output logic              ld_hit,
  output logic [31:0]       ld_fwd_data,
  output logic              ld_conflict,
  output logic              sb_empty,
  output logic [2:0]        sb_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = 3;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // Entry storage, one register set per slot
  logic [31:0]       data_reg  [SB_DEPTH];
  logic [ADDR_W-1:0] addr_reg  [SB_DEPTH];
  logic [3:0]        mask_reg  [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_reg;
  logic [SB_DEPTH-1:0] sent_reg;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  state_t           state_reg;

  logic enq;
  logic issue;
  logic pop;

  // Look-up signals
  logic [SB_DEPTH-1:0] match;
  logic                found;
  logic [PTR_W-1:0]    sel_idx;
  logic [3:0]          sel_mask;
  logic                full_cover;

  // Byte-lane bits of the load address never take part in the word compare.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign commit_ready = (count_reg != CNT_W'(SB_DEPTH));
  assign sb_empty     = (count_reg == '0);
  assign sb_count     = count_reg;

  // A zero-mask commit is a no-op; a commit while full is dropped.
  assign enq   = commit_valid && commit_ready && (commit_mask != 4'h0);
  // Start a request only from IDLE and only once per entry.
  assign issue = (state_reg == S_IDLE) && (count_reg != '0) && !sent_reg[head_reg];
  assign pop   = (state_reg == S_WAIT) && dmem_resp;

  // Occupancy change: simultaneous enqueue and pop cancel out
  always_comb begin
    count_next = count_reg;
    case ({enq, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Queue pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) tail_reg <= tail_reg + PTR_W'(1);
      if (pop) head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
      // Per-slot payload, valid and sent_to_cache tracking
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg[gi] <= 1'b0;
          sent_reg[gi]  <= 1'b0;
          data_reg[gi]  <= '0;
          addr_reg[gi]  <= '0;
          mask_reg[gi]  <= '0;
        end else if (enq && (tail_reg == PTR_W'(gi))) begin
          // Only a free slot can be the tail, so this never races the pop.
          valid_reg[gi] <= 1'b1;
          sent_reg[gi]  <= 1'b0;
          data_reg[gi]  <= commit_data;
          addr_reg[gi]  <= commit_addr;
          mask_reg[gi]  <= commit_mask;
        end else begin
          if (issue && (head_reg == PTR_W'(gi))) sent_reg[gi] <= 1'b1;
          if (pop && (head_reg == PTR_W'(gi))) begin
            valid_reg[gi] <= 1'b0;
            sent_reg[gi]  <= 1'b0;
          end
        end
      end

      // The in-flight head stays visible to loads until its response returns.
      assign match[gi] = valid_reg[gi]
                       && (addr_reg[gi][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])
                       && ((mask_reg[gi] & ld_rmask) != 4'h0);
    end
  endgenerate

  // Drain FSM with registered dcache request outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      dmem_addr  <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (issue) begin
            dmem_addr  <= {addr_reg[head_reg][ADDR_W-1:2], 2'b00};
            dmem_wmask <= mask_reg[head_reg];
            dmem_wdata <= data_reg[head_reg];
            state_reg  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Outputs hold until accepted; dropping wmask forces one idle
          // cycle before the next request.
          if (dmem_resp) begin
            dmem_wmask <= '0;
            state_reg  <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Youngest-match select: scan oldest to youngest so the youngest wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    found   = 1'b0;
    sel_idx = '0;
    idx     = '0;
    for (int k = SB_DEPTH - 1; k >= 0; k--) begin
      idx = tail_reg - PTR_W'(1) - PTR_W'(k);
      if (match[idx]) begin
        found   = 1'b1;
        sel_idx = idx;
      end
    end
  end

  assign sel_mask    = mask_reg[sel_idx];
  assign full_cover  = ((sel_mask & ld_rmask) == ld_rmask);
  assign ld_hit      = found && full_cover;
  assign ld_conflict = found && !full_cover;
  assign ld_fwd_data = ld_hit ? data_reg[sel_idx] : 32'h0;

endmodule

// File: tb/tb_store_buffer_drain.sv
// Self-checking bench for store_buffer_drain: a scoreboard queue holds the
// stores expected on the dcache port, compared as each request appears.
module tb_store_buffer_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [3:0]  commit_mask;
  logic [31:0] commit_data;
  logic        commit_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_hit;
  logic [31:0] ld_fwd_data;
  logic        ld_conflict;
  logic        sb_empty;
  logic [2:0]  sb_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } st_t;

  st_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  logic [3:0] prev_wmask = 4'h0;

  store_buffer_drain dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_mask  (commit_mask),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .dmem_addr    (dmem_addr),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_resp    (dmem_resp),
    .ld_addr      (ld_addr),
    .ld_rmask     (ld_rmask),
    .ld_hit       (ld_hit),
    .ld_fwd_data  (ld_fwd_data),
    .ld_conflict  (ld_conflict),
    .sb_empty     (sb_empty),
    .sb_count     (sb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one commit for a single edge; push to the scoreboard if it should land.
  task automatic commit(input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input bit accept);
    commit_valid = 1'b1;
    commit_addr  = a;
    commit_mask  = m;
    commit_data  = d;
    if (accept) sb_q.push_back('{addr: a, mask: m, data: d});
    $display("commit addr=0x%08h mask=0x%h data=0x%08h accept=%0d", a, m, d, accept);
    step();
    commit_valid = 1'b0;
    commit_mask  = 4'h0;
  endtask

  // Wait (bounded) for an active request, then accept it with a one-cycle resp.
  task automatic drain_one();
    int n = 0;
    while (dmem_wmask == 4'h0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_req_seen", {31'b0, dmem_wmask != 4'h0}, 32'd1);
    if (dmem_wmask != 4'h0) begin
      dmem_resp = 1'b1;
      step();
      dmem_resp = 1'b0;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] m,
                      input logic hit, input logic conf, input logic [31:0] d);
    ld_addr  = a;
    ld_rmask = m;
    #1;
    $display("load addr=0x%08h rmask=0x%h hit=%0d conflict=%0d data=0x%08h",
             a, m, ld_hit, ld_conflict, ld_fwd_data);
    chk("ld_hit", {31'b0, ld_hit}, {31'b0, hit});
    chk("ld_conflict", {31'b0, ld_conflict}, {31'b0, conf});
    chk("ld_fwd_data", ld_fwd_data, d);
  endtask

  // Scoreboard monitor: each new request (wmask rising from zero) is checked
  // against the oldest expected store.
  always @(negedge clk) begin
    if (dmem_wmask != 4'h0 && prev_wmask == 4'h0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_req", {28'b0, dmem_wmask}, 32'h0);
      end else begin
        st_t e;
        e = sb_q.pop_front();
        $display("drain addr=0x%08h mask=0x%h data=0x%08h", dmem_addr, dmem_wmask, dmem_wdata);
        chk("dmem_addr", dmem_addr, {e.addr[31:2], 2'b00});
        chk("dmem_wmask", {28'b0, dmem_wmask}, {28'b0, e.mask});
        chk("dmem_wdata", dmem_wdata, e.data);
      end
    end
    prev_wmask <= dmem_wmask;
  end

  initial begin
    rst = 1'b0;
    commit_valid = 1'b0;
    commit_addr = '0;
    commit_mask = '0;
    commit_data = '0;
    dmem_resp = 1'b0;
    ld_addr = '0;
    ld_rmask = '0;

    // Reset then idle
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_count", {29'b0, sb_count}, 32'd0);
    chk("rst_ready", {31'b0, commit_ready}, 32'd1);
    chk("rst_wmask", {28'b0, dmem_wmask}, 32'd0);

    // Single store with held request
    commit(32'h1000_0004, 4'hF, 32'hDEAD_BEEF, 1'b1);
    chk("single_count", {29'b0, sb_count}, 32'd1);
    chk("single_no_early_req", {28'b0, dmem_wmask}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("hold_addr", dmem_addr, 32'h1000_0004);
      chk("hold_wmask", {28'b0, dmem_wmask}, 32'hF);
      chk("hold_wdata", dmem_wdata, 32'hDEAD_BEEF);
      step();
    end
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk("single_wmask_off", {28'b0, dmem_wmask}, 32'd0);
    chk("single_empty", {31'b0, sb_empty}, 32'd1);

    // Fill, drop when full, partial drain, wrap, full drain in order
    for (int i = 0; i < 4; i++)
      commit(32'h0000_0100 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), 1'b1);
    chk("full_ready", {31'b0, commit_ready}, 32'd0);
    chk("full_count", {29'b0, sb_count}, 32'd4);
    commit(32'h0000_0200, 4'hF, 32'hBAD0_BAD0, 1'b0);
    chk("full_drop_count", {29'b0, sb_count}, 32'd4);
    drain_one();
    drain_one();
    step();
    chk("half_count", {29'b0, sb_count}, 32'd2);
    commit(32'h0000_0110, 4'h3, 32'hB000_0004, 1'b1);
    commit(32'h0000_0114, 4'hC, 32'hB000_0005, 1'b1);
    for (int i = 0; i < 4; i++) drain_one();
    step();
    chk("wrap_empty", {31'b0, sb_empty}, 32'd1);

    // Forwarding: youngest matching store wins
    commit(32'h0000_2000, 4'h3, 32'h0000_1234, 1'b1);
    commit(32'h0000_2000, 4'hF, 32'hAABB_CCDD, 1'b1);
    step();
    load(32'h0000_2000, 4'h3, 1'b1, 1'b0, 32'hAABB_CCDD);
    load(32'h0000_2004, 4'hF, 1'b0, 1'b0, 32'h0);
    load(32'h0000_2000, 4'h0, 1'b0, 1'b0, 32'h0);
    drain_one();
    drain_one();

    // Partial coverage conflict, then miss once drained
    commit(32'h0000_3000, 4'h1, 32'h0000_00AA, 1'b1);
    load(32'h0000_3000, 4'hF, 1'b0, 1'b1, 32'h0);
    drain_one();
    step();
    load(32'h0000_3000, 4'hF, 1'b0, 1'b0, 32'h0);

    // Reset during WAIT with three entries; later resp must be ignored
    for (int i = 0; i < 3; i++)
      commit(32'h0000_4000 + 32'(i * 4), 4'hF, 32'hC000_0000 + 32'(i), 1'b1);
    step();
    chk("pre_rst_count", {29'b0, sb_count}, 32'd3);
    rst = 1'b0;
    #1;
    sb_q.delete();
    chk("mid_rst_count", {29'b0, sb_count}, 32'd0);
    chk("mid_rst_wmask", {28'b0, dmem_wmask}, 32'd0);
    chk("mid_rst_ready", {31'b0, commit_ready}, 32'd1);
    step();
    rst = 1'b1;
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk("post_rst_count", {29'b0, sb_count}, 32'd0);
    chk("post_rst_wmask", {28'b0, dmem_wmask}, 32'd0);

    // Normal operation resumes after reset
    commit(32'h0000_5008, 4'h6, 32'h0012_3400, 1'b1);
    drain_one();
    step();
    chk("final_empty", {31'b0, sb_empty}, 32'd1);
    chk("sb_left", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
